// File: rtl/chacha_axil_pkg.sv
// Shared constants and types for the ChaCha20 AXI4-Lite register block.
package chacha_axil_pkg;

  localparam logic [31:0] ADDR_VERSION   = 32'h0000_0000;
  localparam logic [31:0] ADDR_CONTROL   = 32'h0000_0004;
  localparam logic [31:0] ADDR_KEY       = 32'h0000_0008;
  localparam logic [31:0] ADDR_IV        = 32'h0000_0028;
  localparam logic [31:0] ADDR_DATA_SIZE = 32'h0000_0034;
  localparam logic [31:0] ADDR_DATA_IN   = 32'h0001_0000;
  localparam logic [31:0] ADDR_DATA_OUT  = 32'h0002_0000;

  localparam logic [31:0] VERSION_DEFAULT = 32'h1000_0000;

  localparam int unsigned CTRL_RESETN     = 0;
  localparam int unsigned CTRL_DATA_VALID = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned KEY_WORDS = 8;
  localparam int unsigned IV_WORDS  = 3;

  typedef enum logic [2:0] {
    REGION_NONE,
    REGION_VERSION,
    REGION_CONTROL,
    REGION_KEY,
    REGION_IV,
    REGION_DATA_SIZE,
    REGION_DATA_IN,
    REGION_DATA_OUT
  } region_t;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

endpackage

// File: rtl/chacha_axil_regs_if.sv
// AXI4-Lite bus bundle between the host interconnect and the ChaCha register block.
interface chacha_axil_regs_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic [ADDR_W-1:0] s_axi_awaddr;
  logic              s_axi_awvalid;
  logic              s_axi_awready;
  logic [DATA_W-1:0] s_axi_wdata;
  logic              s_axi_wvalid;
  logic              s_axi_wready;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready;
  logic [ADDR_W-1:0] s_axi_araddr;
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  logic [DATA_W-1:0] s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rvalid;
  logic              s_axi_rready;

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid, s_axi_bready,
           s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid, s_axi_bready,
           s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

endinterface

// File: rtl/chacha_axil_decode.sv
// Address decoder: maps a byte address to a register region and word index.
module chacha_axil_decode
  import chacha_axil_pkg::*;
#(
  parameter int unsigned NUMBER_OF_BLOCKS = 1,
  parameter int unsigned ADDR_W           = 32,
  parameter int unsigned IDX_W            = 4
) (
  input  logic [ADDR_W-1:0] addr,
  output region_t           region,
  output logic [IDX_W-1:0]  idx,
  output logic              writable,
  output logic              legal
);

  localparam logic [31:0] DATA_WORDS = 32'(16 * NUMBER_OF_BLOCKS);

  logic [31:0] wa;
  logic [31:0] off;

  // Decode on word address so the byte-lane bits are ignored.
  always_comb begin
    wa     = 32'(addr) >> 2;
    region = REGION_NONE;
    off    = '0;
    if (wa == (ADDR_VERSION >> 2)) begin
      region = REGION_VERSION;
    end else if (wa == (ADDR_CONTROL >> 2)) begin
      region = REGION_CONTROL;
    end else if (wa >= (ADDR_KEY >> 2) && wa < (ADDR_KEY >> 2) + 32'(KEY_WORDS)) begin
      region = REGION_KEY;
      off    = wa - (ADDR_KEY >> 2);
    end else if (wa >= (ADDR_IV >> 2) && wa < (ADDR_IV >> 2) + 32'(IV_WORDS)) begin
      region = REGION_IV;
      off    = wa - (ADDR_IV >> 2);
    end else if (wa == (ADDR_DATA_SIZE >> 2)) begin
      region = REGION_DATA_SIZE;
    end else if (wa >= (ADDR_DATA_IN >> 2) && wa < (ADDR_DATA_IN >> 2) + DATA_WORDS) begin
      region = REGION_DATA_IN;
      off    = wa - (ADDR_DATA_IN >> 2);
    end else if (wa >= (ADDR_DATA_OUT >> 2) && wa < (ADDR_DATA_OUT >> 2) + DATA_WORDS) begin
      region = REGION_DATA_OUT;
      off    = wa - (ADDR_DATA_OUT >> 2);
    end
    idx      = IDX_W'(off);
    writable = (region == REGION_CONTROL) || (region == REGION_KEY) ||
               (region == REGION_IV) || (region == REGION_DATA_IN);
    legal    = (region != REGION_NONE);
  end

endmodule

// File: rtl/chacha_axil_regs.sv
// AXI4-Lite responder and register file for the ChaCha20 core.
module chacha_axil_regs
  import chacha_axil_pkg::*;
#(
  parameter int unsigned NUMBER_OF_BLOCKS   = 1,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter logic [31:0] VERSION            = VERSION_DEFAULT
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  chacha_axil_regs_if.slave             s_axi,
  output logic                          core_resetn,
  output logic [255:0]                  key,
  output logic [95:0]                   iv,
  output logic [512*NUMBER_OF_BLOCKS-1:0] data_in,
  input  logic [512*NUMBER_OF_BLOCKS-1:0] data_out,
  input  logic                          data_valid
);

  localparam int unsigned DATA_WORDS = 16 * NUMBER_OF_BLOCKS;
  localparam int unsigned IDX_W      = $clog2(DATA_WORDS);

  w_state_t                      w_state;
  r_state_t                      r_state;
  region_t                       wr_region, rd_region;
  logic [IDX_W-1:0]              wr_idx, rd_idx;
  logic                          wr_writable, wr_legal;
  logic                          rd_writable_unused, rd_legal;
  logic                          wr_commit, rd_commit;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;

  chacha_axil_decode #(
    .NUMBER_OF_BLOCKS (NUMBER_OF_BLOCKS),
    .ADDR_W           (C_S_AXI_ADDR_WIDTH),
    .IDX_W            (IDX_W)
  ) u_wr_decode (
    .addr     (s_axi.s_axi_awaddr),
    .region   (wr_region),
    .idx      (wr_idx),
    .writable (wr_writable),
    .legal    (wr_legal)
  );

  chacha_axil_decode #(
    .NUMBER_OF_BLOCKS (NUMBER_OF_BLOCKS),
    .ADDR_W           (C_S_AXI_ADDR_WIDTH),
    .IDX_W            (IDX_W)
  ) u_rd_decode (
    .addr     (s_axi.s_axi_araddr),
    .region   (rd_region),
    .idx      (rd_idx),
    .writable (rd_writable_unused),
    .legal    (rd_legal)
  );

  // Handshake edges: AW/W and AR each complete when their ready pulse meets valid.
  always_comb begin
    wr_commit = (w_state == W_IDLE) && s_axi.s_axi_awready &&
                s_axi.s_axi_awvalid && s_axi.s_axi_wvalid;
    rd_commit = (r_state == R_IDLE) && s_axi.s_axi_arready && s_axi.s_axi_arvalid;
  end

  // Write channel FSM: joint AW/W ready pulse, then hold B until accepted.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state             <= W_IDLE;
      s_axi.s_axi_awready <= 1'b0;
      s_axi.s_axi_wready  <= 1'b0;
      s_axi.s_axi_bvalid  <= 1'b0;
      s_axi.s_axi_bresp   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (wr_commit) begin
            s_axi.s_axi_awready <= 1'b0;
            s_axi.s_axi_wready  <= 1'b0;
            s_axi.s_axi_bvalid  <= 1'b1;
            s_axi.s_axi_bresp   <= wr_legal ? RESP_OKAY : RESP_SLVERR;
            w_state             <= W_RESP;
          end else if (!s_axi.s_axi_awready && s_axi.s_axi_awvalid && s_axi.s_axi_wvalid) begin
            s_axi.s_axi_awready <= 1'b1;
            s_axi.s_axi_wready  <= 1'b1;
          end else begin
            s_axi.s_axi_awready <= 1'b0;
            s_axi.s_axi_wready  <= 1'b0;
          end
        end
        W_RESP: begin
          if (s_axi.s_axi_bready) begin
            s_axi.s_axi_bvalid <= 1'b0;
            w_state            <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Register file update on the write handshake edge; read-only targets are dropped.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      core_resetn <= 1'b0;
      key         <= '0;
      iv          <= '0;
      data_in     <= '0;
    end else if (wr_commit && wr_writable) begin
      case (wr_region)
        REGION_CONTROL: core_resetn <= s_axi.s_axi_wdata[CTRL_RESETN];
        REGION_KEY: begin
          for (int unsigned i = 0; i < KEY_WORDS; i++)
            if (wr_idx == IDX_W'(i)) key[32*i +: 32] <= s_axi.s_axi_wdata;
        end
        REGION_IV: begin
          for (int unsigned i = 0; i < IV_WORDS; i++)
            if (wr_idx == IDX_W'(i)) iv[32*i +: 32] <= s_axi.s_axi_wdata;
        end
        REGION_DATA_IN: begin
          for (int unsigned i = 0; i < DATA_WORDS; i++)
            if (wr_idx == IDX_W'(i)) data_in[32*i +: 32] <= s_axi.s_axi_wdata;
        end
        default: ;
      endcase
    end
  end

  // Read mux over current register contents and live core outputs.
  always_comb begin
    rd_word = '0;
    case (rd_region)
      REGION_VERSION: rd_word = VERSION;
      REGION_CONTROL: begin
        rd_word[CTRL_RESETN]     = core_resetn;
        rd_word[CTRL_DATA_VALID] = data_valid;
      end
      REGION_KEY: begin
        for (int unsigned i = 0; i < KEY_WORDS; i++)
          if (rd_idx == IDX_W'(i)) rd_word = key[32*i +: 32];
      end
      REGION_IV: begin
        for (int unsigned i = 0; i < IV_WORDS; i++)
          if (rd_idx == IDX_W'(i)) rd_word = iv[32*i +: 32];
      end
      REGION_DATA_SIZE: rd_word = 32'(64 * NUMBER_OF_BLOCKS);
      REGION_DATA_IN: begin
        for (int unsigned i = 0; i < DATA_WORDS; i++)
          if (rd_idx == IDX_W'(i)) rd_word = data_in[32*i +: 32];
      end
      REGION_DATA_OUT: begin
        for (int unsigned i = 0; i < DATA_WORDS; i++)
          if (rd_idx == IDX_W'(i)) rd_word = data_out[32*i +: 32];
      end
      default: rd_word = '0;
    endcase
  end

  // Read channel FSM: data is captured at the AR handshake edge, before any
  // same-edge write commit lands, so a colliding read sees the old value.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state             <= R_IDLE;
      s_axi.s_axi_arready <= 1'b0;
      s_axi.s_axi_rvalid  <= 1'b0;
      s_axi.s_axi_rdata   <= '0;
      s_axi.s_axi_rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (rd_commit) begin
            s_axi.s_axi_arready <= 1'b0;
            s_axi.s_axi_rvalid  <= 1'b1;
            s_axi.s_axi_rdata   <= rd_word;
            s_axi.s_axi_rresp   <= rd_legal ? RESP_OKAY : RESP_SLVERR;
            r_state             <= R_DATA;
          end else if (!s_axi.s_axi_arready && s_axi.s_axi_arvalid && !s_axi.s_axi_rvalid) begin
            s_axi.s_axi_arready <= 1'b1;
          end else begin
            s_axi.s_axi_arready <= 1'b0;
          end
        end
        R_DATA: begin
          if (s_axi.s_axi_rready) begin
            s_axi.s_axi_rvalid <= 1'b0;
            r_state            <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
